// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decodes ALUOp/FuncCode and executes single-cycle ops, or a shift-add
// unsigned multiply into HI/LO, behind valid/ready handshakes on both sides.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       func_code,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       alu_ctl,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  // state | meaning
  // IDLE  | waiting for an op; in_ready high
  // BUSY  | multu iterating, one multiplier bit per cycle
  // HOLD  | result presented; out_valid high until out_ready
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [3:0] CTL_AND = 4'd0,  CTL_OR   = 4'd1,  CTL_ADD  = 4'd2;
  localparam logic [3:0] CTL_XOR = 4'd3,  CTL_SUB  = 4'd6,  CTL_SLT  = 4'd7;
  localparam logic [3:0] CTL_SLTU = 4'd8, CTL_MULT = 4'd9,  CTL_MFHI = 4'd10;
  localparam logic [3:0] CTL_MFLO = 4'd11, CTL_NOR = 4'd12, CTL_ILL  = 4'd15;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [3:0]         alu_ctl_q, alu_ctl_d;
  logic               zero_q, zero_d;
  logic               overflow_q, overflow_d;
  logic               illegal_q, illegal_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;

  logic [3:0]         ctl;
  logic [WIDTH-1:0]   sum, diff, exec_res;
  logic               ovf;
  logic [2*WIDTH-1:0] acc_sum;

  always_comb begin
    ctl = CTL_ILL;
    case (alu_op)
      2'd0: ctl = CTL_ADD;
      2'd1: ctl = CTL_SUB;
      default: begin
        case (func_code)
          6'd32, 6'd33: ctl = CTL_ADD;
          6'd34, 6'd35: ctl = CTL_SUB;
          6'd36:        ctl = CTL_AND;
          6'd37:        ctl = CTL_OR;
          6'd38:        ctl = CTL_XOR;
          6'd39:        ctl = CTL_NOR;
          6'd42:        ctl = CTL_SLT;
          6'd43:        ctl = CTL_SLTU;
          6'd25:        ctl = CTL_MULT;
          6'd16:        ctl = CTL_MFHI;
          6'd18:        ctl = CTL_MFLO;
          default:      ctl = CTL_ILL;
        endcase
      end
    endcase
  end

  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

  always_comb begin
    exec_res = '0;
    case (ctl)
      CTL_ADD:  exec_res = sum;
      CTL_SUB:  exec_res = diff;
      CTL_AND:  exec_res = op_a & op_b;
      CTL_OR:   exec_res = op_a | op_b;
      CTL_XOR:  exec_res = op_a ^ op_b;
      CTL_NOR:  exec_res = ~(op_a | op_b);
      CTL_SLT:  exec_res = WIDTH'($signed(op_a) < $signed(op_b));
      CTL_SLTU: exec_res = WIDTH'(op_a < op_b);
      CTL_MFHI: exec_res = hi_q;
      CTL_MFLO: exec_res = lo_q;
      default:  exec_res = '0;
    endcase
  end

  // Only the trapping forms flag overflow; addu/subu and load/store address adds never do.
  always_comb begin
    ovf = 1'b0;
    if (alu_op == 2'd1 || (alu_op[1] && func_code == 6'd34))
      ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
    else if (alu_op[1] && func_code == 6'd32)
      ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
  end

  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    alu_ctl_d  = alu_ctl_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    illegal_d  = illegal_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (ctl == CTL_MULT) begin
            mcand_d  = {{WIDTH{1'b0}}, op_a};
            mplier_d = op_b;
            acc_d    = '0;
            cnt_d    = CNT_W'(WIDTH - 1);
            state_d  = BUSY;
          end else begin
            result_d   = exec_res;
            alu_ctl_d  = ctl;
            zero_d     = (exec_res == '0);
            overflow_d = ovf;
            illegal_d  = (ctl == CTL_ILL);
            state_d    = HOLD;
          end
        end
      end
      BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          hi_d       = acc_sum[2*WIDTH-1:WIDTH];
          lo_d       = acc_sum[WIDTH-1:0];
          result_d   = acc_sum[WIDTH-1:0];
          alu_ctl_d  = CTL_MULT;
          zero_d     = (acc_sum[WIDTH-1:0] == '0);
          overflow_d = 1'b0;
          illegal_d  = 1'b0;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      result_q   <= '0;
      alu_ctl_q  <= CTL_ILL;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      illegal_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      alu_ctl_q  <= alu_ctl_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
      illegal_q  <= illegal_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign result    = result_q;
  assign alu_ctl   = alu_ctl_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit at WIDTH = 32; expected values are hand-computed.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   alu_op;
  logic [5:0]   func_code;
  logic [W-1:0] op_a, op_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   alu_ctl;
  logic         zero, overflow, illegal;

  int n_vec = 0;
  int n_err = 0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .func_code(func_code), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .alu_ctl(alu_ctl),
    .zero(zero), .overflow(overflow), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op for a single cycle; returns just after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [5:0] fc,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    chk("issue_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; alu_op = op; func_code = fc; op_a = a; op_b = b;
    tick();
    in_valid = 1'b0; op_a = '0; op_b = '0;
  endtask

  task automatic complete();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("done_out_valid", 64'(out_valid), 64'd0);
  endtask

  task automatic single(input string tag, input logic [1:0] op, input logic [5:0] fc,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_res, input logic [3:0] exp_ctl,
                        input logic exp_zero, input logic exp_ovf, input logic exp_ill);
    issue(op, fc, a, b);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_result"}, 64'(result), 64'(exp_res));
    chk({tag, "_ctl"}, 64'(alu_ctl), 64'(exp_ctl));
    chk({tag, "_zero"}, 64'(zero), 64'(exp_zero));
    chk({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
    chk({tag, "_ill"}, 64'(illegal), 64'(exp_ill));
    complete();
  endtask

  task automatic multu(input string tag, input logic [1:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp_lo, input logic exp_zero);
    int n;
    issue(op, 6'd25, a, b);
    n = 1;
    while (!out_valid && n < 100) begin
      chk({tag, "_busy_in_ready"}, 64'(in_ready), 64'd0);
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(W + 1));
    chk({tag, "_result"}, 64'(result), 64'(exp_lo));
    chk({tag, "_ctl"}, 64'(alu_ctl), 64'd9);
    chk({tag, "_zero"}, 64'(zero), 64'(exp_zero));
    complete();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = '0; func_code = '0; op_a = '0; op_b = '0;
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_ctl", 64'(alu_ctl), 64'd15);
    chk("rst_result", 64'(result), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    single("mfhi_rst", 2'd2, 6'd16, 32'h1234, 32'h5678, 32'h0, 4'd10, 1'b1, 1'b0, 1'b0);
    single("add_ovf", 2'd2, 6'd32, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'd2, 1'b0, 1'b1, 1'b0);
    single("addu", 2'd2, 6'd33, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'd2, 1'b0, 1'b0, 1'b0);
    single("ldst_add", 2'd0, 6'd63, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'd2, 1'b0, 1'b0, 1'b0);
    single("sub_ovf", 2'd3, 6'd34, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 4'd6, 1'b0, 1'b1, 1'b0);
    single("slt", 2'd2, 6'd42, 32'hFFFF_FFFF, 32'h1, 32'h1, 4'd7, 1'b0, 1'b0, 1'b0);
    single("sltu", 2'd2, 6'd43, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'd8, 1'b1, 1'b0, 1'b0);
    single("nor", 2'd2, 6'd39, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F, 4'd12, 1'b0, 1'b0, 1'b0);
    single("xor", 2'd2, 6'd38, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 4'd3, 1'b0, 1'b0, 1'b0);
    single("and", 2'd2, 6'd36, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 4'd0, 1'b0, 1'b0, 1'b0);
    single("or", 2'd2, 6'd37, 32'hFF00_0000, 32'h0000_00FF, 32'hFF00_00FF, 4'd1, 1'b0, 1'b0, 1'b0);

    // Branch subtract held under backpressure.
    issue(2'd1, 6'd0, 32'd5, 32'd5);
    for (int i = 0; i < 3; i++) begin
      chk("beq_valid", 64'(out_valid), 64'd1);
      chk("beq_result", 64'(result), 64'd0);
      chk("beq_zero", 64'(zero), 64'd1);
      chk("beq_ctl", 64'(alu_ctl), 64'd6);
      chk("beq_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("beq_done_valid", 64'(out_valid), 64'd0);
    chk("beq_done_in_ready", 64'(in_ready), 64'd1);

    multu("mul_a", 2'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0);
    single("mfhi_a", 2'd2, 6'd16, 32'h0, 32'h0, 32'h1, 4'd10, 1'b0, 1'b0, 1'b0);
    single("mflo_a", 2'd2, 6'd18, 32'h0, 32'h0, 32'hFFFF_FFFE, 4'd11, 1'b0, 1'b0, 1'b0);
    multu("mul_b", 2'd3, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1);
    single("mfhi_b", 2'd2, 6'd16, 32'h0, 32'h0, 32'h1, 4'd10, 1'b0, 1'b0, 1'b0);

    // Reset during BUSY cycle 10 abandons the multiply.
    issue(2'd2, 6'd25, 32'd3, 32'd4);
    for (int i = 1; i < 10; i++) tick();
    chk("abort_busy", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    tick();
    chk("abort_still_idle", 64'(out_valid), 64'd0);
    single("mfhi_abort", 2'd2, 6'd16, 32'h0, 32'h0, 32'h0, 4'd10, 1'b1, 1'b0, 1'b0);
    single("mflo_abort", 2'd2, 6'd18, 32'h0, 32'h0, 32'h0, 4'd11, 1'b1, 1'b0, 1'b0);
    single("illegal", 2'd2, 6'd63, 32'hDEAD_BEEF, 32'h1, 32'h0, 4'd15, 1'b1, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised successor to the combinational ALU control decoder: decodes ALUOp/FuncCode and executes the operation on WIDTH-bit operands.
- Wraps decode, a registered single-cycle datapath, an iterative unsigned multiplier and HI/LO registers behind valid/ready handshakes.
- Sits in the EX stage of the multi-cycle datapath. The controller issues on in_valid/in_ready and stalls until out_valid/out_ready completes.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 4).
- CNT_W, $clog2(WIDTH)+1, multiply iteration counter width (derived, do not override).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; high only in IDLE.
- alu_op  in  2  0 = load/store (add), 1 = branch (sub), 2/3 = R-type (decode func_code).
- func_code  in  6  R-type function field.
- op_a  in  WIDTH  operand A (rs).
- op_b  in  WIDTH  operand B (rt).
- out_valid  out  1  result available; held until out_ready.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  operation result.
- alu_ctl  out  4  registered decoded control code of the completed op.
- zero  out  1  result == 0.
- overflow  out  1  signed overflow; add (32) and sub (34, also alu_op 1) only.
- illegal  out  1  unsupported func_code.

Behaviour:
- Reset (rst_n low at a clock edge):
  - State goes to IDLE. in_ready reads 1 from the first cycle after reset.
  - out_valid, result, zero, overflow and illegal go to 0. alu_ctl goes to 15.
  - HI, LO and the iteration counter go to 0.
  - Reset overrides everything, including a multiply in progress. That multiply is abandoned and HI/LO are not written.
- Decode to alu_ctl:
  - alu_op 0 → 2 (add); alu_op 1 → 6 (sub).
  - alu_op 2/3 by func_code: 32/33 → 2 add; 34/35 → 6 sub; 36 → 0 and; 37 → 1 or; 38 → 3 xor; 39 → 12 nor; 42 → 7 slt (signed); 43 → 8 sltu; 25 → 9 multu; 16 → 10 mfhi; 18 → 11 mflo.
  - Any other func_code → 15 (illegal).
- States: IDLE, BUSY, HOLD.
- IDLE:
  - in_ready = 1. An operation is accepted when in_valid and in_ready are both high.
  - Accepted non-multiply op: the result is registered and the unit enters HOLD. out_valid rises exactly 1 cycle after acceptance.
  - Accepted multu: op_a and op_b are latched, the product accumulator and counter are cleared, and the unit enters BUSY.
- BUSY:
  - in_ready = 0; inputs are ignored.
  - Shift-add, one multiplier bit per cycle, for WIDTH cycles.
  - On the last iteration, {HI, LO} is written with the 2·WIDTH-bit unsigned product, result = LO, and the unit enters HOLD.
  - out_valid rises WIDTH+1 cycles after acceptance.
- HOLD:
  - out_valid = 1. All output fields stay stable while out_ready = 0.
  - When out_ready = 1: out_valid drops next cycle and the unit returns to IDLE.
  - A new op cannot be accepted in the same cycle as the out_ready completion; peak throughput is 1 op per 2 cycles.
- Arithmetic rules:
  - add/sub wrap modulo 2^WIDTH.
  - overflow = operand sign bits agree (add), or differ (sub), and the result sign differs from op_a's sign. overflow = 0 for all other ops, including 33/35.
  - slt/sltu give 1 or 0 zero-extended to WIDTH bits.
  - nor = ~(op_a | op_b).
  - mfhi/mflo return the current HI/LO, single-cycle. Only multu writes HI/LO.
- Illegal op:
  - Single-cycle path: result = 0, zero = 1, illegal = 1, alu_ctl = 15.
  - HI/LO unchanged.
- zero is computed on the registered result for every op, including multu (LO == 0).

Test Plan:
- Reset and IDLE: hold rst_n low 2 cycles → out_valid = 0, alu_ctl = 15, in_ready = 1 the cycle after release. Then mfhi → result = 0.
- Add overflow, WIDTH = 32: alu_op = 2, func = 32, A = 0x7FFFFFFF, B = 1 → one cycle later out_valid = 1, result = 0x80000000, overflow = 1, alu_ctl = 2. The same operands with func = 33 → overflow = 0.
- Branch subtract with backpressure: alu_op = 1, A = B = 5, out_ready held 0 for 3 cycles → result = 0, zero = 1, alu_ctl = 6, all held stable. in_ready = 0 until the cycle after out_ready = 1.
- slt vs sltu: A = 0xFFFFFFFF, B = 1 → func 42 gives result = 1; func 43 gives result = 0, alu_ctl = 8.
- multu then mfhi/mflo: A = 0xFFFFFFFF, B = 2 → out_valid after 33 cycles, result = LO = 0xFFFFFFFE, in_ready = 0 throughout BUSY. Following mfhi → 1; mflo → 0xFFFFFFFE.
- Reset mid-multiply, then illegal op:
  - Start multu 3×4, assert rst_n low on BUSY cycle 10 → IDLE next cycle, HI = LO = 0, no out_valid.
  - Then func = 63 → result = 0, illegal = 1, zero = 1, alu_ctl = 15.
